// File: rtl/modport_slave_pkg.sv
// Shared types and constants for the modport_slave AXI4-Lite register file.
package modport_slave_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Write channel: wait for AW+W together, one-cycle ready, then hold B.
  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_ACK  = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  // Read channel: wait for AR, one-cycle ready, then hold R.
  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ACK  = 2'b01,
    R_DATA = 2'b10
  } rd_state_t;

endpackage

// File: rtl/modport_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface modport_slave_if #(
  parameter int N_BYTES    = 4,
  parameter int ADDR_WIDTH = 12
) ();

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [8*N_BYTES-1:0]  WDATA;
  logic [N_BYTES-1:0]    WSTRB;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [8*N_BYTES-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID,    input WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input RREADY
  );

endinterface

// File: rtl/modport_slave.sv
// AXI4-Lite slave register file: N_REGS words, byte-strobe writes,
// single-outstanding independent read and write channels.
// Build option MODPORT_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY (writes are dropped and reads return 0 either way).
//
//  write state | meaning
//  W_IDLE      | waiting for AWVALID and WVALID together
//  W_ACK       | AWREADY/WREADY high; handshake edge updates the register
//  W_RESP      | BVALID high until BREADY
//
//  read state  | meaning
//  R_IDLE      | waiting for ARVALID
//  R_ACK       | ARREADY high; handshake edge captures RDATA/RRESP
//  R_DATA      | RVALID high, RDATA/RRESP held until RREADY
module modport_slave
  import modport_slave_pkg::*;
#(
  parameter int N_BYTES    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int N_REGS     = 16
) (
  input  logic           ACLK,
  input  logic           ARESET,
  modport_slave_if.slave bus
);

  localparam int DW  = 8 * N_BYTES;
  localparam int LSB = $clog2(N_BYTES);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int RIW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

`ifdef MODPORT_SLAVE_SLVERR_EN
  localparam axi_resp_t RESP_OOR = RESP_SLVERR;
`else
  localparam axi_resp_t RESP_OOR = RESP_OKAY;
`endif

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  axi_resp_t bresp_q, bresp_d;
  axi_resp_t rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] regs_q [N_REGS];
  logic          reg_we;

  // Word index decode; low byte-lane address bits are ignored.
  logic [IW-1:0]  aw_idx, ar_idx;
  logic [RIW-1:0] aw_ridx, ar_ridx;
  logic           aw_in_range, ar_in_range;

  assign aw_idx      = bus.AWADDR[ADDR_WIDTH-1:LSB];
  assign ar_idx      = bus.ARADDR[ADDR_WIDTH-1:LSB];
  assign aw_ridx     = aw_idx[RIW-1:0];
  assign ar_ridx     = ar_idx[RIW-1:0];
  assign aw_in_range = (32'(aw_idx) < 32'(N_REGS));
  assign ar_in_range = (32'(ar_idx) < 32'(N_REGS));

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.AWPROT, bus.ARPROT,
                         bus.AWADDR[LSB-1:0], bus.ARADDR[LSB-1:0]};

  // Bus outputs decode straight from the state and response flops.
  assign bus.AWREADY = (wr_state_q == W_ACK);
  assign bus.WREADY  = (wr_state_q == W_ACK);
  assign bus.BVALID  = (wr_state_q == W_RESP);
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = (rd_state_q == R_ACK);
  assign bus.RVALID  = (rd_state_q == R_DATA);
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  // Write channel next state, response and register write enable.
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    reg_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (bus.AWVALID && bus.WVALID) wr_state_d = W_ACK;
      end
      W_ACK: begin
        // A master that withdrew a valid just loses this slot and retries.
        if (bus.AWVALID && bus.WVALID) begin
          reg_we     = aw_in_range;
          bresp_d    = aw_in_range ? RESP_OKAY : RESP_OOR;
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (bus.BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel state and response registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read channel next state; data is sampled from the pre-write register
  // contents, so a same-edge write to the same word is not visible yet.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (bus.ARVALID) rd_state_d = R_ACK;
      end
      R_ACK: begin
        if (bus.ARVALID) begin
          rdata_d    = ar_in_range ? regs_q[ar_ridx] : '0;
          rresp_d    = ar_in_range ? RESP_OKAY : RESP_OOR;
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (bus.RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel state, data and response registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Register array with per-byte strobe merge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int r = 0; r < N_REGS; r++) regs_q[r] <= '0;
    end else if (reg_we) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (bus.WSTRB[b]) regs_q[aw_ridx][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench for modport_slave: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_modport_slave;

  localparam int NB  = 4;
  localparam int AW  = 12;
  localparam int NR  = 16;
  localparam int DW  = 8 * NB;

`ifdef MODPORT_SLAVE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;

  modport_slave_if #(.N_BYTES(NB), .ADDR_WIDTH(AW)) bus ();

  modport_slave #(.N_BYTES(NB), .ADDR_WIDTH(AW), .N_REGS(NR)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0]   model_q [NR];
  logic [1:0]      exp_b [$];
  logic [DW+1:0]   exp_r [$];
  bit b_due, r_due, awr_prev, arr_prev;

  // Compare process: at each falling edge, check live responses against the
  // model, then record the handshakes the coming rising edge will complete.
  always @(negedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NR; i++) model_q[i] = '0;
      exp_b.delete();
      exp_r.delete();
      b_due = 0; r_due = 0; awr_prev = 0; arr_prev = 0;
    end else begin
      if (b_due) check("b_latency", bus.BVALID, 1);
      if (r_due) check("r_latency", bus.RVALID, 1);
      b_due = 0;
      r_due = 0;
      if (bus.BVALID) begin
        if (exp_b.size() == 0) check("b_spurious", bus.BVALID, 0);
        else begin
          check("bresp", bus.BRESP, exp_b[0]);
          if (bus.BREADY) void'(exp_b.pop_front());
        end
      end
      if (bus.RVALID) begin
        if (exp_r.size() == 0) check("r_spurious", bus.RVALID, 0);
        else begin
          check("rdata", bus.RDATA, exp_r[0][DW-1:0]);
          check("rresp", bus.RRESP, exp_r[0][DW+1:DW]);
          if (bus.RREADY) void'(exp_r.pop_front());
        end
      end
      if (awr_prev) check("awready_pulse", bus.AWREADY, 0);
      if (arr_prev) check("arready_pulse", bus.ARREADY, 0);
      if (bus.AWREADY) begin
        check("wready_pair", bus.WREADY, 1);
        check("aw_while_b", bus.BVALID, 0);
      end
      if (bus.ARREADY) check("ar_while_r", bus.RVALID, 0);
      awr_prev = bus.AWREADY;
      arr_prev = bus.ARREADY;
      // Reads first so a same-edge read sees the old word.
      if (bus.ARVALID && bus.ARREADY) begin
        int ridx;
        ridx = int'(bus.ARADDR) / NB;
        if (ridx < NR) exp_r.push_back({2'b00, model_q[ridx]});
        else exp_r.push_back({OOR_RESP, {DW{1'b0}}});
        r_due = 1;
      end
      if (bus.AWVALID && bus.WVALID && bus.AWREADY) begin
        int widx;
        widx = int'(bus.AWADDR) / NB;
        if (widx < NR) begin
          for (int b = 0; b < NB; b++)
            if (bus.WSTRB[b]) model_q[widx][8*b +: 8] = bus.WDATA[8*b +: 8];
          exp_b.push_back(2'b00);
        end else begin
          exp_b.push_back(OOR_RESP);
        end
        b_due = 1;
      end
    end
  end

  // ---------------- master-side drivers ----------------
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  // br_dl < 0 holds BREADY high from the start.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [NB-1:0] s, input int aw_dl, input int w_dl,
                    input int br_dl, output logic [1:0] resp);
    int cyc, hs_cyc, both, bcnt;
    bit hs, done;
    resp = 2'bxx;
    both = (aw_dl > w_dl) ? aw_dl : w_dl;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    if (br_dl < 0) bus.BREADY = 1'b1;
    done = 0; cyc = 0; hs_cyc = -1;
    while (!done && cyc < 40) begin
      if (cyc >= aw_dl) bus.AWVALID = 1'b1;
      if (cyc >= w_dl)  bus.WVALID  = 1'b1;
      hs = bus.AWVALID && bus.WVALID && bus.AWREADY;
      if (hs) hs_cyc = cyc;
      tick();
      done = hs;
      cyc++;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.AWADDR = AW'($urandom); bus.WDATA = DW'($urandom);
    check("aw_latency", hs_cyc, both + 1);
    done = 0; cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (br_dl < 0 || cyc >= br_dl) bus.BREADY = 1'b1;
      if (bus.BVALID) bcnt++;
      hs = bus.BVALID && bus.BREADY;
      if (hs) resp = bus.BRESP;
      tick();
      done = hs;
      cyc++;
    end
    bus.BREADY = 1'b0;
    check("b_done", done, 1);
    check("b_cycles", bcnt, (br_dl < 0) ? 1 : br_dl + 1);
  endtask

  // rr_dl < 0 holds RREADY high from the start.
  task automatic rd(input logic [AW-1:0] a, input int ar_dl, input int rr_dl,
                    output logic [DW-1:0] data, output logic [1:0] resp);
    int cyc, hs_cyc, rcnt;
    bit hs, done;
    data = 'x; resp = 2'bxx;
    bus.ARADDR = a;
    if (rr_dl < 0) bus.RREADY = 1'b1;
    done = 0; cyc = 0; hs_cyc = -1;
    while (!done && cyc < 40) begin
      if (cyc >= ar_dl) bus.ARVALID = 1'b1;
      hs = bus.ARVALID && bus.ARREADY;
      if (hs) hs_cyc = cyc;
      tick();
      done = hs;
      cyc++;
    end
    bus.ARVALID = 1'b0;
    bus.ARADDR = AW'($urandom);
    check("ar_latency", hs_cyc, ar_dl + 1);
    done = 0; cyc = 0; rcnt = 0;
    while (!done && cyc < 40) begin
      if (rr_dl < 0 || cyc >= rr_dl) bus.RREADY = 1'b1;
      if (bus.RVALID) rcnt++;
      hs = bus.RVALID && bus.RREADY;
      if (hs) begin data = bus.RDATA; resp = bus.RRESP; end
      tick();
      done = hs;
      cyc++;
    end
    bus.RREADY = 1'b0;
    check("r_done", done, 1);
    check("r_cycles", rcnt, (rr_dl < 0) ? 1 : rr_dl + 1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(NR * NB, (1 << AW) - 1));
    return AW'($urandom_range(0, NR * NB - 1));
  endfunction

  function automatic int rand_dl();
    return int'($urandom_range(0, 4)) - 1;
  endfunction

  // Watchdog in case a handshake wedges the clocked loops.
  initial begin
    #500us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rdat, rdat2;
    logic [1:0]    rsp, rsp2;
    bit hs;

    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;

    repeat (3) tick();
    check("rst_awready", bus.AWREADY, 0);
    check("rst_wready",  bus.WREADY, 0);
    check("rst_bvalid",  bus.BVALID, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid",  bus.RVALID, 0);
    check("rst_bresp",   bus.BRESP, 0);
    check("rst_rresp",   bus.RRESP, 0);
    check("rst_rdata",   bus.RDATA, 0);
    ARESET = 1'b0;
    tick();

    rd(12'h000, 0, 0, rdat, rsp);
    check("rd0_data", rdat, 0);
    check("rd0_resp", rsp, 0);

    wr(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, rsp);
    check("wr4_resp", rsp, 0);
    rd(12'h004, 0, 1, rdat, rsp);
    check("rd4_data", rdat, 32'hDEADBEEF);
    check("rd4_resp", rsp, 0);
    rd(12'h006, 1, 0, rdat, rsp);
    check("rd6_lowbits", rdat, 32'hDEADBEEF);

    wr(12'h008, 32'h11223344, 4'hF, 0, 0, 2, rsp);
    wr(12'h008, 32'hAABBCCDD, 4'b0101, 0, 0, 0, rsp);
    rd(12'h008, 0, 0, rdat, rsp);
    check("rd8_strobe", rdat, 32'h11BB33DD);
    check("model_strobe", model_q[2], 32'h11BB33DD);

    wr(12'h00C, 32'h12345678, 4'hF, 0, 3, 0, rsp);
    rd(12'h00C, 0, 0, rdat, rsp);
    check("rdC_aw_first", rdat, 32'h12345678);
    wr(12'h010, 32'h0BADF00D, 4'hF, 3, 0, 1, rsp);
    rd(12'h010, 2, 0, rdat, rsp);
    check("rd10_w_first", rdat, 32'h0BADF00D);

    wr(12'h014, 32'hCAFE0014, 4'hF, 0, 0, -1, rsp);
    rd(12'h014, 0, -1, rdat, rsp);
    check("rd14_held_ready", rdat, 32'hCAFE0014);

    wr(12'h400, 32'hCAFEF00D, 4'hF, 0, 0, 0, rsp);
    check("oor_bresp", rsp, OOR_RESP);
    rd(12'h400, 0, 0, rdat, rsp);
    check("oor_rdata", rdat, 0);
    check("oor_rresp", rsp, OOR_RESP);
    rd(12'h000, 0, 0, rdat, rsp);
    check("oor_no_alias", rdat, 0);

    wr(12'h018, 32'h01010101, 4'hF, 0, 0, 0, rsp);
    fork
      wr(12'h018, 32'h02020202, 4'hF, 0, 0, 0, rsp2);
      rd(12'h018, 0, 0, rdat2, rsp);
    join
    check("same_edge_old", rdat2, 32'h01010101);
    rd(12'h018, 0, 0, rdat, rsp);
    check("same_edge_new", rdat, 32'h02020202);

    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        wr(rand_addr(), DW'($urandom), NB'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), rand_dl(), rsp);
      end else if (op == 1) begin
        rd(rand_addr(), int'($urandom_range(0, 3)), rand_dl(), rdat, rsp);
      end else begin
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [NB-1:0] ws;
        int d0, d1, d2, d3, d4;
        wa = rand_addr(); ra = rand_addr(); wd = DW'($urandom); ws = NB'($urandom);
        d0 = int'($urandom_range(0, 3)); d1 = int'($urandom_range(0, 3));
        d2 = rand_dl(); d3 = int'($urandom_range(0, 3)); d4 = rand_dl();
        fork
          wr(wa, wd, ws, d0, d1, d2, rsp2);
          rd(ra, d3, d4, rdat2, rsp);
        join
      end
    end

    // Reset while a write response is pending.
    bus.AWADDR = 12'h004; bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    for (int i = 0; i < 10 && !bus.BVALID; i++) begin
      hs = bus.AWREADY;
      tick();
      if (hs) begin bus.AWVALID = 1'b0; bus.WVALID = 1'b0; end
    end
    check("pre_rst_bvalid", bus.BVALID, 1);
    ARESET = 1'b1;
    #1;
    check("async_rst_bvalid", bus.BVALID, 0);
    check("async_rst_awready", bus.AWREADY, 0);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    repeat (2) tick();
    ARESET = 1'b0;
    tick();
    check("post_rst_bvalid", bus.BVALID, 0);
    rd(12'h004, 0, 0, rdat, rsp);
    check("post_rst_cleared", rdat, 0);
    rd(12'h018, 0, 0, rdat, rsp);
    check("post_rst_cleared2", rdat, 0);

    repeat (3) tick();
    check("b_queue_drained", exp_b.size(), 0);
    check("r_queue_drained", exp_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
